// File: rtl/bike_reg_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : bike_reg_bank_array
// Purpose  : Multi-bank register array. Each bank holds BANK_SIZE words. A
//            valid/ready word stream fills a bank through an auto-incrementing
//            write pointer. Banks can be read one word at a time (registered,
//            1-cycle latency) or all at once on the flat dout bus. Each bank
//            has full/empty status and its own clear. An optional ring mode
//            wraps the write pointer after the bank is full.
// Ports    : clk, reset (sync, active-high), clear[NUM_OF_BANKS]
//            wr_valid/wr_bank/wr_data -> wr_ready (combinational)
//            rd_req/rd_bank/rd_addr   -> rd_valid/rd_data (registered)
//            full/empty per bank, dout = flat view of every word
// Revision : 1.0 - initial release
// ============================================================================
module bike_reg_bank_array #(
    parameter int NUM_OF_BANKS = 4,
    parameter int BANK_SIZE    = 8,
    parameter int WORD_WIDTH   = 32,
    parameter int WRAP         = 0,
    parameter int BSEL_W       = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    parameter int PTR_W        = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_OF_BANKS-1:0]                    clear,
    input  logic                                       wr_valid,
    input  logic [BSEL_W-1:0]                          wr_bank,
    input  logic [WORD_WIDTH-1:0]                      wr_data,
    output logic                                       wr_ready,
    input  logic                                       rd_req,
    input  logic [BSEL_W-1:0]                          rd_bank,
    input  logic [PTR_W-1:0]                           rd_addr,
    output logic                                       rd_valid,
    output logic [WORD_WIDTH-1:0]                      rd_data,
    output logic [NUM_OF_BANKS-1:0]                    full,
    output logic [NUM_OF_BANKS-1:0]                    empty,
    output logic [NUM_OF_BANKS*BANK_SIZE*WORD_WIDTH-1:0] dout
);

    localparam int             c_BANK_BITS  = BANK_SIZE * WORD_WIDTH;
    localparam int             c_TOTAL_BITS = NUM_OF_BANKS * c_BANK_BITS;
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(BANK_SIZE - 1);

    typedef enum logic [0:0] {
        S_FILLING = 1'b0,
        S_FULL    = 1'b1
    } bank_state_t;

    // Per-bank results gathered as nets so each bank's generate block drives
    // only its own slice.
    wire [NUM_OF_BANKS-1:0] w_accept;
    wire [NUM_OF_BANKS-1:0] w_full;
    wire [NUM_OF_BANKS-1:0] w_empty;
    wire [c_TOTAL_BITS-1:0] w_flat;

    logic [WORD_WIDTH-1:0]  w_rd_word;
    logic                   r_rd_valid;
    logic [WORD_WIDTH-1:0]  r_rd_data;

    // At most one bank matches wr_bank. An out-of-range bank matches none,
    // so the OR reduction also covers the out-of-range case.
    assign wr_ready = |w_accept;

    generate
        for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
            logic [PTR_W-1:0]       r_ptr;
            logic                   r_empty;
            logic [c_BANK_BITS-1:0] r_words;
            bank_state_t            r_state;
            bank_state_t            w_state_nxt;
            logic                   w_hit;
            logic                   w_last;
            logic                   w_xfer;

            assign w_hit  = (wr_bank == BSEL_W'(b));
            assign w_last = (r_ptr == c_LAST_PTR);
            // A clear in the same cycle blocks the write, so clear always wins.
            assign w_accept[b] = w_hit & ~clear[b] &
                                 ((WRAP != 0) | (r_state == S_FILLING));
            assign w_xfer = wr_valid & w_accept[b];

            always_comb begin
                w_state_nxt = r_state;
                if (clear[b]) begin
                    w_state_nxt = S_FILLING;
                end else if (w_xfer && w_last) begin
                    w_state_nxt = S_FULL;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= S_FILLING;
                    r_ptr   <= '0;
                    r_empty <= 1'b1;
                    r_words <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (clear[b]) begin
                        r_ptr   <= '0;
                        r_empty <= 1'b1;
                        r_words <= '0;
                    end else if (w_xfer) begin
                        r_empty <= 1'b0;
                        for (int k = 0; k < BANK_SIZE; k++) begin
                            if (r_ptr == PTR_W'(k)) begin
                                r_words[k*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                            end
                        end
                        // Without ring mode the pointer parks on the last slot;
                        // further writes are already refused through wr_ready.
                        if (!w_last) begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end else if (WRAP != 0) begin
                            r_ptr <= '0;
                        end
                    end
                end
            end

            assign w_full[b]  = (r_state == S_FULL);
            assign w_empty[b] = r_empty;
            assign w_flat[b*c_BANK_BITS +: c_BANK_BITS] = r_words;
        end
    endgenerate

    // Word select from the register contents as they stand before the edge,
    // so a read colliding with a write/clear of the same slot returns old data.
    // Out-of-range bank or address matches nothing and yields zero.
    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            for (int k = 0; k < BANK_SIZE; k++) begin
                if ((rd_bank == BSEL_W'(b)) && (rd_addr == PTR_W'(k))) begin
                    w_rd_word = w_flat[(b*BANK_SIZE+k)*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign full     = w_full;
    assign empty    = w_empty;
    assign dout     = w_flat;

endmodule
`default_nettype wire

// File: doc/bike_reg_bank_array.md
Name: bike_reg_bank_array

Overview:
- Parametrised multi-bank register array storing NUM_OF_BANKS values of BANK_SIZE*WORD_WIDTH bits each (default: 4 x 256 bit).
- Each bank is filled by a valid/ready word stream with an auto-incrementing write pointer.
- Banks are read back either word-addressed with registered 1-cycle latency or in parallel on a flat bus.
- Provides per-bank full/empty status, per-bank clear, and an optional ring (wrap) mode for BIKE sampling and key buffers.

Parameters:
- NUM_OF_BANKS, 4, number of independent banks (>=1).
- BANK_SIZE, 8, words per bank (>=2).
- WORD_WIDTH, 32, bits per word.
- WRAP, 0, 0 = bank stops at full; 1 = ring mode, overwrite from slot 0 after full.
- BSEL_W, max(1,$clog2(NUM_OF_BANKS)), derived, bank select width.
- PTR_W, max(1,$clog2(BANK_SIZE)), derived, word address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high global reset.
- clear  in  NUM_OF_BANKS  per-bank synchronous clear, active-high.
- wr_valid  in  1  write word offered.
- wr_bank  in  BSEL_W  target bank of write.
- wr_data  in  WORD_WIDTH  write word.
- wr_ready  out  1  write accepted this cycle if wr_valid=1 (combinational).
- rd_req  in  1  read request.
- rd_bank  in  BSEL_W  bank to read.
- rd_addr  in  PTR_W  word index to read.
- rd_valid  out  1  rd_data valid (registered pulse).
- rd_data  out  WORD_WIDTH  read word (registered).
- full  out  NUM_OF_BANKS  bank holds BANK_SIZE words.
- empty  out  NUM_OF_BANKS  bank holds 0 words since last reset/clear.
- dout  out  NUM_OF_BANKS*BANK_SIZE*WORD_WIDTH  flat parallel contents.

Behaviour:
- Reset (clk edge with reset=1):
  - All words = 0; all wr_ptr = 0; full = 0; empty = all ones.
  - rd_valid = 0; rd_data = 0.
  - reset overrides every other input.
- Layout: word k of bank b sits at dout[(b*BANK_SIZE+k)*WORD_WIDTH +: WORD_WIDTH]. dout is a direct register view, not pipelined.
- wr_ready (combinational):
  - 0 if wr_bank >= NUM_OF_BANKS.
  - 0 if clear[wr_bank]=1.
  - 0 if WRAP=0 and full[wr_bank]=1.
  - 1 otherwise.
- Write handshake: transfer occurs when wr_valid && wr_ready. Data goes to slot wr_ptr[wr_bank]. Next cycle:
  - wr_ptr[wr_bank] increments.
  - empty[wr_bank] = 0.
- Pointer end: on the write to slot BANK_SIZE-1, full[b] = 1 next cycle.
  - WRAP=0: wr_ptr stays at BANK_SIZE-1; further writes are refused via wr_ready=0.
  - WRAP=1: wr_ptr wraps to 0; full stays 1; next write overwrites slot 0.
- Per-bank state: a 2-state FSM (FILLING, FULL) per bank.
  - FILLING -> FULL on the last-slot write.
  - FULL -> FILLING only on clear or reset.
- Clear: clear[b]=1 zeroes all words of b, wr_ptr[b] = 0, full[b] = 0, empty[b] = 1 at the next edge.
  - Clear wins over a simultaneous write to the same bank (wr_ready=0, so no transfer).
  - Writes to other banks in the same cycle proceed normally.
- Read: rd_req=1 at edge N gives rd_data = word[rd_bank][rd_addr] and rd_valid = 1 after edge N.
  - rd_valid is 0 on any cycle without a request.
  - rd_data holds its last value when rd_req=0.
  - Out-of-range bank or addr >= BANK_SIZE: rd_data = 0, rd_valid = 1.
- Read during write/clear of the same slot in the same cycle returns the pre-edge (old) value.
- Reads do not depend on full; unwritten slots read 0.
- One write and one read per cycle, fully pipelined, no stalls.

Test Plan:
- Reset then idle: after reset, empty=4'b1111, full=0, dout=0, rd_valid=0, wr_ready=1 for wr_bank=0.
- Fill bank 2 with 8 words 0x1000_0000+i, wr_valid held high -> wr_ready=1 for 8 cycles, then 0. full=4'b0100, empty=4'b1011. dout word (2*8+i) = 0x1000_0000+i.
- Read bank 2 addr 5 -> rd_valid=1 one cycle later with rd_data=0x1000_0005. Read addr 5 of empty bank 1 -> rd_data=0.
- Simultaneous clear[2]=1 and write to bank 2 plus write to bank 0 -> wr_ready=0 for bank 2. Bank 2 all zero, full[2]=0, empty[2]=1. Bank 0 slot 0 = written data.
- WRAP=1 build: write 10 words 0xA0..0xA9 to bank 0 -> full[0]=1 after the 8th. Slots 0,1 = 0xA8,0xA9; slots 2..7 = 0xA2..0xA7; wr_ready never 0.
- Reset asserted mid-fill (after 3 words to bank 1) together with wr_valid -> next cycle all contents 0, empty all ones, write not stored.
